// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode/execute hazard inputs
// and the PC / IF-ID / ID-EX sequencing controls returned to the datapath.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_mdu_start;
    logic             id_mfhilo;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic             ex_branch_taken;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_mdu_start, id_mfhilo,
               idex_memread, idex_rt, ex_branch_taken,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, mdu_busy, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_mdu_start, id_mfhilo,
               idex_memread, idex_rt, ex_branch_taken,
        output pc_en, ifid_en, ifid_flush, idex_bubble, mdu_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use and MDU stalls, EX-resolved
// branch squash, MDU latency tracking and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    localparam int unsigned MDU_CNT_W = 8;

    logic [MDU_CNT_W-1:0] mdu_cnt;
    logic [CNT_W-1:0]     stall_q;
    logic                 lu_haz;
    logic                 mdu_haz;
    logic                 mdu_issue;

    // Hazard detection against the load in EX and the in-flight MDU op
    always_comb begin
        lu_haz  = bus.idex_memread
                & (bus.idex_rt != 5'd0)
                & ((bus.idex_rt == bus.id_rs)
                   | (bus.id_uses_rt & (bus.idex_rt == bus.id_rt)));
        mdu_haz = (mdu_cnt != '0) & (bus.id_mfhilo | bus.id_mdu_start);
    end

    // Pipeline controls; a taken branch squashes ID so its hazards are moot
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        mdu_issue       = 1'b0;
        if (bus.ex_branch_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (mdu_haz || lu_haz) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_bubble = 1'b1;
        end else begin
            mdu_issue = bus.id_mdu_start;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_cnt <= '0;
            stall_q <= '0;
        end else begin
            if (mdu_issue) begin
                mdu_cnt <= MDU_CNT_W'(MDU_LAT);
            end else if (mdu_cnt != '0) begin
                mdu_cnt <= mdu_cnt - MDU_CNT_W'(1);
            end
            if (!bus.pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign bus.mdu_busy     = (mdu_cnt != '0);
    assign bus.stall_cycles = stall_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sequences the PC register, the IF/ID pipeline register and the ID/EX register, and generates their enable, flush and bubble controls. It resolves three hazards: load-use data hazards, taken branches/jumps resolved in EX, and structural/data hazards against the multi-cycle multiply/divide unit (MDU). It also keeps a saturating count of stall cycles for performance debug.

## Interface
Parameters:
- MDU_LAT, 32: cycles from MDU issue until HI/LO are valid (legal range 1..255).
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt as a source.
- id_mdu_start  in  1  instruction in ID is MULT/MULTU/DIV/DIVU.
- id_mfhilo  in  1  instruction in ID is MFHI/MFLO/MTHI/MTLO.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  5  destination rt of the instruction in EX.
- ex_branch_taken  in  1  branch or jump in EX is taken.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID enable. When 0, IF/ID holds its contents.
- ifid_flush  out  1  IF/ID clears to zero (NOP) at the next edge. Overrides ifid_en.
- idex_bubble  out  1  ID/EX loads a NOP (all control bits 0) at the next edge.
- mdu_busy  out  1  MDU operation in flight.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en==0.

## Operation
- State: mdu_cnt (8 bits), stall_cycles (CNT_W bits). mdu_busy = (mdu_cnt != 0).
- The outputs pc_en, ifid_en, ifid_flush and idex_bubble are combinational from the inputs and mdu_cnt. All other state is registered.
- Hazard conditions:
  - lu_haz = idex_memread & (idex_rt != 0) & ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt))).
  - mdu_haz = mdu_busy & (id_mfhilo | id_mdu_start).
- Priority (highest first):
  - ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1. The wrong-path ID instruction is squashed and any hazard it raises is ignored.
  - mdu_haz: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
  - lu_haz: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
  - Otherwise: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- MDU issue is accepted when id_mdu_start=1 and the no-hazard case applies. On acceptance, mdu_cnt loads MDU_LAT.
- Otherwise, mdu_cnt decrements by 1 when it is nonzero. It never wraps below 0.
- A taken branch does not affect an MDU operation already in flight (it is older than the branch), so mdu_cnt keeps counting.
- stall_cycles increments when pc_en==0 and holds at 2^CNT_W-1 once reached.

## Timing
- Reset values: mdu_cnt=0 and stall_cycles=0. With idle inputs, the outputs are pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, mdu_busy=0.
- Reset mid-MDU-operation clears mdu_cnt immediately, and mdu_busy=0 in the cycle after the reset edge.
- Load-use: the stall lasts exactly 1 cycle, because the load advances to MEM and lu_haz drops. The dependent instruction stays in ID for 2 cycles total.
- MDU: if issue is accepted in cycle T, mdu_busy=1 in cycles T+1..T+MDU_LAT.
  - A dependent MFHI or MULT in ID is held through cycle T+MDU_LAT.
  - It advances at the edge ending cycle T+MDU_LAT+1.
- Branch: the flush/bubble is active for the single cycle ex_branch_taken is high. There is no extra penalty cycle from this block.
- Simultaneous mdu_haz and lu_haz: outputs are identical, and release follows whichever condition persists longer.
- Simultaneous ex_branch_taken and id_mdu_start: the issue is not accepted and mdu_cnt is unchanged.

## Test plan
- Reset check: assert rst for 2 cycles with random inputs -> stall_cycles=0 and mdu_busy=0 afterwards. With idle inputs, pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- Load-use: idex_memread=1, idex_rt=5, id_rs=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_bubble=1 for 1 cycle; stall_cycles=1. Repeat with idex_rt=0, then with id_rt=5 and id_uses_rt=0 -> no stall in either case.
- MDU: MDU_LAT=4, accept id_mdu_start at T, then present id_mfhilo from T+1 -> mdu_busy high T+1..T+4, pc_en=0 T+1..T+4, release at T+5; stall_cycles=4.
- Branch priority: ex_branch_taken=1 together with lu_haz and mdu_haz -> pc_en=1, ifid_flush=1, idex_bubble=1, and no stall_cycles increment. Branch together with id_mdu_start while idle -> mdu_busy stays 0.
- Reset mid-MDU: rst at T+2 of a MDU_LAT=8 operation -> mdu_busy=0 from T+3, and a pending MFHI proceeds without stall.
- Saturation: CNT_W=3, hold lu_haz for 10 cycles -> stall_cycles reaches 7 and holds at 7.
